// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid channel, core redirect,
// and the instruction valid/ready handshake toward the core.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// RV32I fetch front-end: one outstanding word read at a time, returned words
// buffered with their PCs in a small FIFO; a redirect flushes everything in flight.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no request outstanding; issue one when the FIFO has room
// WAIT_GNT | imem_req high, address held until imem_gnt
// WAIT_RD  | request accepted, waiting for imem_rvalid
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          n_rst,
    instr_fetch_if.master bus
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          discard_q, discard_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_pc_d   [DEPTH];
    logic [31:0]   fifo_word_q [DEPTH];
    logic [31:0]   fifo_word_d [DEPTH];

    logic push;
    logic pop;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_word_d = fifo_word_q;
        push        = 1'b0;
        pop         = (count_q != '0) && bus.instr_ready;

        // Issue decision uses the registered count only, so instr_ready never
        // reaches the request path combinationally.
        case (state_q)
            IDLE: begin
                if (count_q < FULL) begin
                    state_d  = WAIT_GNT;
                    req_pc_d = fetch_pc_q;
                end
            end
            WAIT_GNT: begin
                if (bus.imem_gnt) begin
                    state_d = WAIT_RD;
                    if (!discard_q) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            WAIT_RD: begin
                if (bus.imem_rvalid) begin
                    state_d = IDLE;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything; a granted-but-unreturned request
        // cannot be retracted, so its response is marked for dropping.
        if (bus.redirect) begin
            pop        = 1'b0;
            push       = 1'b0;
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            case (state_q)
                IDLE: begin
                    state_d  = IDLE;
                    req_pc_d = req_pc_q;
                end
                WAIT_GNT: discard_d = 1'b1;
                WAIT_RD:  discard_d = !bus.imem_rvalid;
                default:  discard_d = 1'b0;
            endcase
        end

        if (bus.redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = req_pc_q;
                fifo_word_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d              = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            discard_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_word_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_word_q <= fifo_word_d;
        end
    end

    assign bus.imem_req    = (state_q == WAIT_GNT);
    assign bus.imem_addr   = req_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = fifo_word_q[rd_ptr_q];
    assign bus.instr_pc    = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: bus handshakes are driven cycle by cycle and
// every observation is compared against hand-derived values.
module tb_instr_fetch;

    logic clk;
    logic n_rst;
    int   n_assert;
    int   n_fail;

    instr_fetch_if bus_if ();

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Request must be up at address a; grant it at once, return data one cycle later.
    // Ends in IDLE right after the push edge.
    task automatic do_fetch(input logic [31:0] a);
        chk("req_up", 32'(bus_if.imem_req), 32'd1);
        chk("req_addr", bus_if.imem_addr, a);
        bus_if.imem_gnt = 1'b1;
        step();
        chk("req_low_in_wait_rd", 32'(bus_if.imem_req), 32'd0);
        bus_if.imem_gnt   = 1'b0;
        bus_if.imem_rvalid = 1'b1;
        bus_if.imem_rdata  = mem(a);
        step();
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = 32'h0;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(bus_if.instr_valid), 32'd1);
        chk({tag, "_pc"}, bus_if.instr_pc, pc);
        chk({tag, "_word"}, bus_if.instr, mem(pc));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        bus_if.imem_gnt    = 1'b0;
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = 32'h0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'h0;
        bus_if.instr_ready = 1'b1;

        // Reset values
        step();
        step();
        chk("rst_req", 32'(bus_if.imem_req), 32'd0);
        chk("rst_addr", bus_if.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("rst_instr", bus_if.instr, 32'h0);
        chk("rst_pc", bus_if.instr_pc, 32'h0);
        n_rst = 1'b1;

        // Streaming with instr_ready=1: one fetch every three cycles
        step();
        do_fetch(32'h0);
        chk_head("a0", 32'h0);
        step();
        chk("a_pop_empty", 32'(bus_if.instr_valid), 32'd0);
        do_fetch(32'h4);
        chk_head("a4", 32'h4);
        step();
        do_fetch(32'h8);
        chk_head("a8", 32'h8);
        step();
        chk("a_next_addr", bus_if.imem_addr, 32'hC);

        // Backpressure: two words buffered, then requests stop
        n_rst = 1'b0;
        #1;
        n_rst = 1'b1;
        bus_if.instr_ready = 1'b0;
        step();
        do_fetch(32'h0);
        chk_head("b0", 32'h0);
        step();
        do_fetch(32'h4);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("b_stall_req", 32'(bus_if.imem_req), 32'd0);
            chk("b_stall_pc", bus_if.instr_pc, 32'h0);
        end
        bus_if.instr_ready = 1'b1;
        step();
        chk_head("b4", 32'h4);
        step();
        chk("b_empty", 32'(bus_if.instr_valid), 32'd0);
        do_fetch(32'h8);
        chk_head("b8", 32'h8);
        bus_if.instr_ready = 1'b0;

        // Redirect while waiting for read data
        step();
        chk("c_addr", bus_if.imem_addr, 32'hC);
        bus_if.imem_gnt = 1'b1;
        step();
        bus_if.imem_gnt    = 1'b0;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h100;
        step();
        bus_if.redirect = 1'b0;
        chk("c_flush", 32'(bus_if.instr_valid), 32'd0);
        chk("c_no_req", 32'(bus_if.imem_req), 32'd0);
        bus_if.imem_rvalid = 1'b1;
        bus_if.imem_rdata  = mem(32'hC);
        step();
        bus_if.imem_rvalid = 1'b0;
        chk("c_dropped", 32'(bus_if.instr_valid), 32'd0);
        step();
        do_fetch(32'h100);
        chk_head("c100", 32'h100);

        // Redirect while grant is held off: old address stays, its data is dropped
        bus_if.instr_ready = 1'b1;
        step();
        bus_if.instr_ready = 1'b0;
        chk("d_addr", bus_if.imem_addr, 32'h104);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h203;
        step();
        bus_if.redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("d_hold_req", 32'(bus_if.imem_req), 32'd1);
            chk("d_hold_addr", bus_if.imem_addr, 32'h104);
            step();
        end
        bus_if.imem_gnt = 1'b1;
        step();
        bus_if.imem_gnt    = 1'b0;
        bus_if.imem_rvalid = 1'b1;
        bus_if.imem_rdata  = mem(32'h104);
        step();
        bus_if.imem_rvalid = 1'b0;
        chk("d_dropped", 32'(bus_if.instr_valid), 32'd0);
        step();
        do_fetch(32'h200);
        chk_head("d200", 32'h200);

        // Push and pop in the same cycle with one word buffered
        step();
        chk("e_addr", bus_if.imem_addr, 32'h204);
        bus_if.imem_gnt = 1'b1;
        step();
        bus_if.imem_gnt    = 1'b0;
        bus_if.imem_rvalid = 1'b1;
        bus_if.imem_rdata  = mem(32'h204);
        bus_if.instr_ready = 1'b1;
        step();
        bus_if.imem_rvalid = 1'b0;
        bus_if.instr_ready = 1'b0;
        chk_head("e204", 32'h204);
        step();
        chk("e_still_204", bus_if.instr_pc, 32'h204);
        chk("e_addr2", bus_if.imem_addr, 32'h208);

        // Redirect coincident with rvalid: word dropped, discard stays clear
        bus_if.imem_gnt = 1'b1;
        step();
        bus_if.imem_gnt    = 1'b0;
        bus_if.imem_rvalid = 1'b1;
        bus_if.imem_rdata  = mem(32'h208);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h300;
        step();
        bus_if.imem_rvalid = 1'b0;
        bus_if.redirect    = 1'b0;
        chk("f_flush", 32'(bus_if.instr_valid), 32'd0);
        step();
        do_fetch(32'h300);
        chk_head("f300", 32'h300);

        // Fetch PC wrap-around
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus_if.redirect = 1'b0;
        chk("g_flush", 32'(bus_if.instr_valid), 32'd0);
        step();
        do_fetch(32'hFFFF_FFFC);
        chk_head("g_top", 32'hFFFF_FFFC);
        step();
        chk("g_wrap_addr", bus_if.imem_addr, 32'h0);
        do_fetch(32'h0);
        bus_if.instr_ready = 1'b1;
        step();
        step();
        bus_if.instr_ready = 1'b0;
        chk("h_addr", bus_if.imem_addr, 32'h4);

        // Reset in WAIT_RD, then a late response after release
        bus_if.imem_gnt = 1'b1;
        step();
        bus_if.imem_gnt = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("h_rst_req", 32'(bus_if.imem_req), 32'd0);
        chk("h_rst_addr", bus_if.imem_addr, 32'h0);
        chk("h_rst_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("h_rst_instr", bus_if.instr, 32'h0);
        chk("h_rst_pc", bus_if.instr_pc, 32'h0);
        n_rst = 1'b1;
        bus_if.imem_rvalid = 1'b1;
        bus_if.imem_rdata  = mem(32'h4);
        step();
        bus_if.imem_rvalid = 1'b0;
        chk("h_late_ignored", 32'(bus_if.instr_valid), 32'd0);
        do_fetch(32'h0);
        chk_head("h0", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
